// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - pipeline load/hold/flush sequencer with data-memory handshake
module hazard_stall_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [4:0]             Id_rs,
  input  logic [4:0]             Id_rt,
  input  logic                   Ex_memRead,
  input  logic [4:0]             Ex_RegRd,
  input  logic                   Ex_redirect,
  input  logic                   Mem_memRead,
  input  logic                   Mem_memWrite,
  input  logic                   dmem_ready,
  output logic                   dmem_req,
  output logic                   pc_write,
  output logic                   IfId_write,
  output logic                   IfId_flush,
  output logic                   IdEx_write,
  output logic                   IdEx_flush,
  output logic                   ExMem_write,
  output logic                   MemWb_flush,
  output logic                   mem_err,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  // wait_cnt must hold 0..MEM_TIMEOUT-1; keep at least one bit for MEM_TIMEOUT=1
  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_t;

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              memacc;
  logic              memstall;
  logic              load_use;

  // Memory-access and hazard detection; everything is forced quiet while rst is low
  always_comb begin
    memacc   = Mem_memRead | Mem_memWrite;
    load_use = Ex_memRead & (Ex_RegRd != 5'd0) &
               ((Ex_RegRd == Id_rs) | (Ex_RegRd == Id_rt));
    memstall = 1'b0;
    dmem_req = 1'b0;
    if (rst) begin
      case (state)
        RUN: begin
          memstall = memacc & ~dmem_ready;
          dmem_req = memacc;
        end
        MEM_WAIT: begin
          memstall = ~dmem_ready;
          dmem_req = memacc;
        end
        default: begin
          memstall = 1'b1;
          dmem_req = 1'b0;
        end
      endcase
    end
  end

  // Pipeline register controls by priority: memory stall, redirect, load-use, normal flow
  always_comb begin
    pc_write    = 1'b1;
    IfId_write  = 1'b1;
    IfId_flush  = 1'b0;
    IdEx_write  = 1'b1;
    IdEx_flush  = 1'b0;
    ExMem_write = 1'b1;
    MemWb_flush = 1'b0;
    if (!rst) begin
      // keep the no-hazard defaults while held in reset
    end else if (memstall) begin
      // freeze everything up to EX/MEM; redirect and load-use wait for release
      pc_write    = 1'b0;
      IfId_write  = 1'b0;
      IdEx_write  = 1'b0;
      ExMem_write = 1'b0;
      MemWb_flush = 1'b1;
    end else if (Ex_redirect) begin
      // the ID instruction is squashed, so a coincident load-use does not matter
      IfId_flush = 1'b1;
      IdEx_flush = 1'b1;
    end else if (load_use) begin
      pc_write   = 1'b0;
      IfId_write = 1'b0;
      IdEx_flush = 1'b1;
    end
  end

  // Handshake FSM, timeout counter, sticky error and saturating stall counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= RUN;
      wait_cnt  <= '0;
      mem_err   <= 1'b0;
      stall_cnt <= '0;
    end else begin
      if (!pc_write && (stall_cnt != {STALL_CNT_W{1'b1}})) begin
        stall_cnt <= stall_cnt + STALL_CNT_W'(1);
      end
      case (state)
        RUN: begin
          if (memacc && !dmem_ready) begin
            state    <= MEM_WAIT;
            wait_cnt <= '0;
          end
        end
        MEM_WAIT: begin
          if (dmem_ready) begin
            state <= RUN;
          end else if (wait_cnt == WAIT_LAST) begin
            state   <= ERR;
            mem_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        default: begin
          state   <= ERR;
          mem_err <= 1'b1;
        end
      endcase
    end
  end

endmodule
